spw_light_pll_supervisor: RTL
=============================

Name: spw_light_pll_supervisor

Overview:
- Reset/lock supervisor for the SpaceWire light PLL, running on the 50 MHz reference clock.
- Drives the PLL reset input and monitors the PLL locked output, including reset pulse generation, lock debounce, lock-timeout retry and loss-of-lock recovery.
- Produces a clean, registered system reset and ready flag for the 200 MHz SpaceWire logic.
- Enters a sticky fault state after repeated lock failures.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles `pll_rst` is held high per reset attempt (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synced-locked cycles required before release (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: refclk cycles allowed in WAIT_LOCK before a retry (≥1).
- MAX_RETRIES, 7: timeouts tolerated before FAULT; `retry_count` width is 3 bits, so the value must be ≤7.
- CNT_W, 17: shared counter width; must hold max(all cycle parameters)−1.

Ports:
- refclk  in  1  50 MHz reference clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
- pll_rst  out  1  PLL reset, active-high.
- sys_rst  out  1  downstream system reset, active-high.
- pll_ready  out  1  high only in RUN.
- retry_count  out  3  timeouts since the last rst or successful RUN entry.
- fault  out  1  sticky lock-failure flag.

Behaviour:
- One clock; reset is synchronous and active-high (refclk, rst).
- `pll_locked` passes through a 2-flop synchroniser (`locked_s`); both flops reset to 0.
- All outputs are registered and decoded from the registered state.
- Reset values while `rst`=1: state=RESET_PLL, cnt=0, pll_rst=1, sys_rst=1, pll_ready=0, retry_count=0, fault=0.
- RESET_PLL:
  - pll_rst=1, sys_rst=1; cnt increments each cycle.
  - At cnt==RST_PULSE_CYCLES−1, go to WAIT_LOCK with cnt=0.
  - pll_rst is high for exactly RST_PULSE_CYCLES cycles after rst drops.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If locked_s=1: go to STABLE_CHECK with cnt=0.
  - Else if cnt==LOCK_TIMEOUT_CYCLES−1 and retry_count==MAX_RETRIES: go to FAULT.
  - Else if cnt==LOCK_TIMEOUT_CYCLES−1: retry_count+1, go to RESET_PLL with cnt=0.
  - Otherwise cnt+1.
- STABLE_CHECK:
  - pll_rst=0, sys_rst=1.
  - If locked_s=0: go to WAIT_LOCK with cnt=0. The timeout window restarts; no retry is counted.
  - Else if cnt==LOCK_STABLE_CYCLES−1: go to RUN and clear retry_count.
  - Otherwise cnt+1.
- RUN:
  - pll_rst=0, sys_rst=0, pll_ready=1.
  - If locked_s=0: go to RESET_PLL with cnt=0 (loss of lock). retry_count stays 0.
- FAULT:
  - pll_rst=1, sys_rst=1, pll_ready=0, fault=1.
  - Only `rst` exits this state.
- Latencies:
  - pll_ready rises LOCK_STABLE_CYCLES+2 edges after the edge that first samples pll_locked=1.
  - sys_rst reasserts and pll_ready falls 2 edges after the edge that first samples pll_locked=0 in RUN.
- Counter behaviour: cnt never wraps; it is cleared on every state change.
- Simultaneous events:
  - rst has priority over all transitions.
  - In WAIT_LOCK, locked_s=1 on the timeout cycle wins (go to STABLE_CHECK, no retry).
- Reset mid-operation (any state, including FAULT and RUN) restarts a full RESET_PLL pulse.
- Invariants:
  - sys_rst == !pll_ready at all times.
  - pll_rst and pll_ready are never both 1.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Nominal lock: release rst, tie pll_locked=1 → pll_rst high exactly 4 cycles. pll_ready=1 and sys_rst=0 exactly 10 edges after pll_locked is first sampled in WAIT_LOCK. retry_count=0.
2. Glitchy lock: pll_locked high 5 cycles, low 1, then high → STABLE_CHECK aborts with no pll_ready. pll_ready rises 10 edges after the final rise. retry_count=0.
3. Timeout/retry: hold pll_locked=0 → two 4-cycle pll_rst pulses, 32 cycles apart after each pulse; retry_count steps 1, 2. Third timeout → fault=1, pll_rst=1 held.
4. Recovery after retries: fail once (retry_count=1), then lock → RUN entry clears retry_count to 0. fault stays 0.
5. Loss of lock: in RUN, drop pll_locked → pll_ready=0 and sys_rst=1 after 2 edges, then a new 4-cycle pll_rst pulse. Relock → RUN again.
6. Reset mid-operation: assert rst for 1 cycle in STABLE_CHECK, and again in FAULT → all outputs at reset values next edge. fault cleared; full RESET_PLL sequence restarts.

Source files
------------

// File: rtl/spw_light_pll_supervisor.sv
// Reset/lock supervisor for the SpaceWire light PLL on the 50 MHz reference clock:
// PLL reset pulses, lock debounce, timeout retry, loss-of-lock recovery and sticky fault.
module spw_light_pll_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic [2:0] retry_count,
  output logic       fault
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE_CHECK,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_retry, w_retry_nxt;
  logic             r_locked_p0, r_locked_p1;
  logic             w_locked_s;
  logic             r_pll_rst, r_sys_rst, r_pll_ready, r_fault;
  logic             w_pll_rst_nxt, w_sys_rst_nxt, w_pll_ready_nxt, w_fault_nxt;

  // Stage p0/p1: two-flop synchroniser for the asynchronous lock indicator
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_locked_p0 <= 1'b0;
      r_locked_p1 <= 1'b0;
    end else begin
      r_locked_p0 <= pll_locked;
      r_locked_p1 <= r_locked_p0;
    end
  end

  assign w_locked_s = r_locked_p1;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= 3'd0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_pll_ready <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_rst   <= w_pll_rst_nxt;
      r_sys_rst   <= w_sys_rst_nxt;
      r_pll_ready <= w_pll_ready_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  // The counter is cleared on every state change and parked at zero in RUN/FAULT
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = S_STABLE_CHECK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_cnt_nxt = '0;
          if (r_retry == RETRY_MAX) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_state_nxt = S_RESET_PLL;
            w_retry_nxt = r_retry + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STABLE_CHECK: begin
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_retry_nxt = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        w_cnt_nxt = '0;
        if (!w_locked_s) begin
          w_state_nxt = S_RESET_PLL;
        end
      end
      S_FAULT: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = S_RESET_PLL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the next state so their flops line up with the state register
  always_comb begin
    w_pll_rst_nxt   = 1'b0;
    w_sys_rst_nxt   = 1'b1;
    w_pll_ready_nxt = 1'b0;
    w_fault_nxt     = 1'b0;
    case (w_state_nxt)
      S_RESET_PLL: w_pll_rst_nxt = 1'b1;
      S_RUN: begin
        w_sys_rst_nxt   = 1'b0;
        w_pll_ready_nxt = 1'b1;
      end
      S_FAULT: begin
        w_pll_rst_nxt = 1'b1;
        w_fault_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign pll_ready   = r_pll_ready;
  assign retry_count = r_retry;
  assign fault       = r_fault;

endmodule
